keccak_rho_pi_stage: RTL and testbench

KECCAK_RHO_PI_STAGE -- requirements
Module: keccak_rho_pi_stage

---
 rtl/keccak_rho_pi_stage_if.sv | 26 ++
 rtl/keccak_rho_pi_stage.sv | 95 +++++++++
 tb/tb_keccak_rho_pi_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/keccak_rho_pi_stage_if.sv
// Handshake and state bus for the Keccak rho/pi stage.
// The design drives the slave side; a source/sink drives the master side.
interface keccak_rho_pi_stage_if #(
    parameter int W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic [25*W-1:0]   in_state;
    logic              out_valid;
    logic              out_ready;
    logic [25*W-1:0]   out_state;
    logic              out_mode;
    logic              busy;
    logic [31:0]       xfer_count;

    modport slave (
        input  in_valid, in_mode, in_state, out_ready,
        output in_ready, out_valid, out_state, out_mode, busy, xfer_count
    );

    modport master (
        output in_valid, in_mode, in_state, out_ready,
        input  in_ready, out_valid, out_state, out_mode, busy, xfer_count
    );
endinterface

// File: rtl/keccak_rho_pi_stage.sv
// Two-stage Keccak rho/pi permutation step with valid/ready flow control.
// Forward mode is rho then pi; inverse mode is pi-inverse then rho-inverse.
module keccak_rho_pi_stage #(
    parameter int W      = 64,
    parameter bit INV_EN = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    keccak_rho_pi_stage_if.slave bus
);
    localparam int RHO [25] = '{
         0,  1, 62, 28, 27,
        36, 44,  6, 55, 20,
         3, 10, 43, 25, 39,
        41, 45, 15, 21,  8,
        18,  2, 61, 56, 14
    };

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int s);
        logic [2*W-1:0] t;
        t = {v, v} << s;
        return t[2*W-1:W];
    endfunction

    logic            s1_valid, s2_valid;
    logic            s1_mode, s2_mode;
    logic [25*W-1:0] s1_data, s2_data;
    logic [25*W-1:0] s1_fwd, s1_inv, s2_fwd, s2_inv;
    logic [25*W-1:0] s1_next, s2_next;
    logic            s1_adv, s2_adv;
    logic            mode_in;
    logic [31:0]     xfer_q;

    assign mode_in = INV_EN && bus.in_mode;

    for (genvar y = 0; y < 5; y++) begin : g_y
        for (genvar x = 0; x < 5; x++) begin : g_x
            localparam int SH  = RHO[x + 5*y] % W;
            localparam int FX  = (x + 3*y) % 5;
            localparam int FY  = x;
            // Source of P[x][y]: the lane A[y][iy] with (y + 3*iy) % 5 == x.
            localparam int IX  = y;
            localparam int IY  = (2 * (x - y + 5)) % 5;
            localparam int L   = x + 5*y;

            assign s1_fwd[L*W +: W] = rotl(bus.in_state[L*W +: W], SH);
            assign s1_inv[L*W +: W] = bus.in_state[(IX + 5*IY)*W +: W];
            assign s2_fwd[L*W +: W] = s1_data[(FX + 5*FY)*W +: W];
            assign s2_inv[L*W +: W] = rotl(s1_data[L*W +: W], (W - SH) % W);
        end
    end

    assign s1_next = mode_in ? s1_inv : s1_fwd;
    assign s2_next = s1_mode ? s2_inv : s2_fwd;

    assign s2_adv = !s2_valid || bus.out_ready;
    assign s1_adv = !s1_valid || s2_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s2_mode  <= 1'b0;
            s1_data  <= '0;
            s2_data  <= '0;
            xfer_q   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_data <= s1_next;
                    s1_mode <= mode_in;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s2_next;
                    s2_mode <= s1_mode;
                end
            end
            if (s2_valid && bus.out_ready) begin
                xfer_q <= xfer_q + 32'd1;
            end
        end
    end

    assign bus.in_ready   = s1_adv;
    assign bus.out_valid  = s2_valid;
    assign bus.out_state  = s2_data;
    assign bus.out_mode   = s2_mode;
    assign bus.busy       = s1_valid || s2_valid;
    assign bus.xfer_count = xfer_q;
endmodule

// File: tb/tb_keccak_rho_pi_stage.sv
// Directed self-checking bench for keccak_rho_pi_stage (W=64, W=8, and W=64 without inverse).
module tb_keccak_rho_pi_stage;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    keccak_rho_pi_stage_if #(.W(64)) b64 ();
    keccak_rho_pi_stage_if #(.W(8))  b8  ();
    keccak_rho_pi_stage_if #(.W(64)) bni ();

    keccak_rho_pi_stage #(.W(64), .INV_EN(1'b1)) u64 (.clk(clk), .rst(rst), .bus(b64));
    keccak_rho_pi_stage #(.W(8),  .INV_EN(1'b1)) u8  (.clk(clk), .rst(rst), .bus(b8));
    keccak_rho_pi_stage #(.W(64), .INV_EN(1'b0)) uni (.clk(clk), .rst(rst), .bus(bni));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1599:0] lane64(input int idx, input logic [63:0] v);
        logic [1599:0] r;
        r = '0;
        r[idx*64 +: 64] = v;
        return r;
    endfunction

    logic [1599:0] rnd, fwd_r, exp64, v2, e2, v3, e3;
    logic [199:0]  v8, e8;

    initial begin
        compared   = 0;
        mismatched = 0;
        clk = 1'b0;
        rst = 1'b1;
        b64.in_valid = 1'b0; b64.in_mode = 1'b0; b64.in_state = '0; b64.out_ready = 1'b1;
        b8.in_valid  = 1'b0; b8.in_mode  = 1'b0; b8.in_state  = '0; b8.out_ready  = 1'b1;
        bni.in_valid = 1'b0; bni.in_mode = 1'b0; bni.in_state = '0; bni.out_ready = 1'b1;
        for (int i = 0; i < 50; i++) rnd[i*32 +: 32] = $urandom;

        // reset state
        tick();
        b64.in_valid = 1'b1; b64.in_state = rnd;
        tick();
        chk("rst_out_valid", b64.out_valid, 1'b0);
        chk("rst_busy", b64.busy, 1'b0);
        chk("rst_xfer", b64.xfer_count, 32'd0);
        chk("rst_out_state", b64.out_state, '0);
        chk("rst_out_mode", b64.out_mode, 1'b0);
        b64.in_valid = 1'b0; b64.in_state = '0;
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", b64.in_ready, 1'b1);

        // single-lane forward vectors, plus INV_EN=0 with in_mode=1
        b64.in_state = lane64(1, 64'h1); b64.in_mode = 1'b0; b64.in_valid = 1'b1;
        bni.in_state = lane64(1, 64'h1); bni.in_mode = 1'b1; bni.in_valid = 1'b1;
        v8 = '0; v8[6*8 +: 8] = 8'h01;
        b8.in_state = v8; b8.in_mode = 1'b0; b8.in_valid = 1'b1;
        tick();
        b64.in_valid = 1'b0; bni.in_valid = 1'b0; b8.in_valid = 1'b0;
        chk("lat_not_early", b64.out_valid, 1'b0);
        tick();
        chk("fwd64_valid", b64.out_valid, 1'b1);
        chk("fwd64_state", b64.out_state, lane64(10, 64'h2));
        chk("fwd64_mode", b64.out_mode, 1'b0);
        e8 = '0; e8[1*8 +: 8] = 8'h10;
        chk("fwd8_state", b8.out_state, e8);
        chk("noinv_state", bni.out_state, lane64(10, 64'h2));
        chk("noinv_mode", bni.out_mode, 1'b0);

        // back-to-back: forward, hand inverse, random forward
        v2 = lane64(0, 64'h8000_0000_0000_0000) | lane64(2, 64'h1);
        e2 = lane64(0, 64'h8000_0000_0000_0000) | lane64(20, 64'h4000_0000_0000_0000);
        v3 = lane64(10, 64'h2);
        e3 = lane64(1, 64'h1);
        b64.in_valid = 1'b1; b64.in_state = v2; b64.in_mode = 1'b0;
        tick();
        b64.in_state = v3; b64.in_mode = 1'b1;
        tick();
        chk("tp1_valid", b64.out_valid, 1'b1);
        chk("tp1_state", b64.out_state, e2);
        b64.in_state = rnd; b64.in_mode = 1'b0;
        tick();
        chk("tp2_valid", b64.out_valid, 1'b1);
        chk("tp2_state", b64.out_state, e3);
        chk("tp2_mode", b64.out_mode, 1'b1);
        b64.in_valid = 1'b0;
        tick();
        chk("tp3_valid", b64.out_valid, 1'b1);
        chk("tp3_mode", b64.out_mode, 1'b0);
        fwd_r = b64.out_state;
        tick();
        b64.in_valid = 1'b1; b64.in_state = fwd_r; b64.in_mode = 1'b1;
        tick();
        b64.in_valid = 1'b0;
        tick();
        chk("rt_state", b64.out_state, rnd);
        chk("rt_mode", b64.out_mode, 1'b1);
        tick();
        chk("xfer_after_tp", b64.xfer_count, 32'd5);

        // backpressure with in_valid held high
        rst = 1'b1; tick(); rst = 1'b0; tick();
        b64.out_ready = 1'b0; b64.in_mode = 1'b0;
        b64.in_valid = 1'b1; b64.in_state = lane64(0, 64'd1);
        tick();
        chk("bp_ready1", b64.in_ready, 1'b1);
        b64.in_state = lane64(0, 64'd2);
        tick();
        chk("bp_ready_full", b64.in_ready, 1'b0);
        b64.in_state = lane64(0, 64'd3);
        tick();
        tick();
        chk("bp_hold_state", b64.out_state, lane64(0, 64'd1));
        chk("bp_hold_ready", b64.in_ready, 1'b0);
        chk("bp_busy", b64.busy, 1'b1);
        b64.out_ready = 1'b1;
        tick();
        b64.in_valid = 1'b0;
        chk("bp_out2", b64.out_state, lane64(0, 64'd2));
        tick();
        chk("bp_out3", b64.out_state, lane64(0, 64'd3));
        chk("bp_out3_valid", b64.out_valid, 1'b1);
        tick();
        chk("bp_drained", b64.out_valid, 1'b0);
        chk("bp_xfer", b64.xfer_count, 32'd3);

        // reset shortly after acceptance discards the state
        rst = 1'b1; tick(); rst = 1'b0; tick();
        b64.in_valid = 1'b1; b64.in_state = lane64(0, 64'd7);
        tick();
        b64.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", b64.busy, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_rst_no_out", b64.out_valid, 1'b0);
        end
        chk("mid_rst_busy_after", b64.busy, 1'b0);
        chk("mid_rst_xfer", b64.xfer_count, 32'd0);
        chk("mid_rst_ready", b64.in_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
